// File: rtl/packet_field_extractor_if.sv
// Packet input stream and extracted-field result bus shared by the parser and its neighbours.
// The master drives beats and consumes results; the slave is the parser.
interface packet_field_extractor_if #(
  parameter int DATA_WIDTH     = 64,
  parameter int FIELD_NUMBER   = 4,
  parameter int FIELD_SIZE_MAX = 4
);
  localparam int MOD_W = $clog2(DATA_WIDTH / 8);

  logic                                   InBus_DataValid;
  logic                                   InBus_DataSop;
  logic                                   InBus_DataEop;
  logic [MOD_W-1:0]                       InBus_Mod;
  logic [DATA_WIDTH-1:0]                  InBus_Data;
  logic                                   InBus_DataRead;
  logic                                   OutBus_Ready;
  logic                                   OutBus_AllValues_Ready;
  logic [FIELD_NUMBER-1:0]                OutBus_Valid;
  logic [FIELD_NUMBER*FIELD_SIZE_MAX*8-1:0] OutBus_Field;
  logic [FIELD_NUMBER-1:0]                error_offset_or_size;

  modport master (
    output InBus_DataValid, InBus_DataSop, InBus_DataEop, InBus_Mod, InBus_Data, OutBus_Ready,
    input  InBus_DataRead, OutBus_AllValues_Ready, OutBus_Valid, OutBus_Field, error_offset_or_size
  );

  modport slave (
    input  InBus_DataValid, InBus_DataSop, InBus_DataEop, InBus_Mod, InBus_Data, OutBus_Ready,
    output InBus_DataRead, OutBus_AllValues_Ready, OutBus_Valid, OutBus_Field, error_offset_or_size
  );
endinterface

// File: rtl/packet_field_extractor.sv
// Streaming header parser: captures FIELD_NUMBER byte fields at programmable offsets/sizes.
// Optional macro PKT_EXTRACT_STATS_EN adds handed-off packet and error counters.
module packet_field_extractor #(
  parameter int DATA_WIDTH     = 64,
  parameter int FIELD_NUMBER   = 4,
  parameter int FIELD_SIZE_MAX = 4,
  parameter int OFFSET_WIDTH   = 8,
  localparam int SEL_W  = (FIELD_NUMBER > 1) ? $clog2(FIELD_NUMBER) : 1,
  localparam int SIZE_W = $clog2(FIELD_SIZE_MAX + 1)
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  packet_field_extractor_if.slave  bus,
  input  logic                     Cfg_We,
  input  logic [SEL_W-1:0]         Cfg_Sel,
  input  logic [OFFSET_WIDTH-1:0]  Cfg_Offset,
  input  logic [SIZE_W-1:0]        Cfg_Size
`ifdef PKT_EXTRACT_STATS_EN
  ,
  output logic [31:0]              Stat_PktCnt,
  output logic [31:0]              Stat_ErrCnt
`endif
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int MOD_W = $clog2(BYTES);
  localparam int OW    = OFFSET_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BODY = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  typedef logic [FIELD_NUMBER-1:0][FIELD_SIZE_MAX-1:0][7:0] fields_t;

  state_e                  state_q;
  logic                    read_q;
  logic                    rdy_q;
  logic [FIELD_NUMBER-1:0] vld_q;
  logic [FIELD_NUMBER-1:0] err_q;
  fields_t                 field_q;
  fields_t                 cap_q;
  fields_t                 cap_d;
  logic [OW-1:0]           cnt_q;

  logic [OW-1:0]     sh_off_q  [FIELD_NUMBER];
  logic [OW-1:0]     sh_off_d  [FIELD_NUMBER];
  logic [OW-1:0]     act_off_q [FIELD_NUMBER];
  logic [OW-1:0]     eff_off_s [FIELD_NUMBER];
  logic [SIZE_W-1:0] sh_sz_q   [FIELD_NUMBER];
  logic [SIZE_W-1:0] sh_sz_d   [FIELD_NUMBER];
  logic [SIZE_W-1:0] act_sz_q  [FIELD_NUMBER];
  logic [SIZE_W-1:0] eff_sz_s  [FIELD_NUMBER];

  logic                    accept_s;
  logic                    sop_s;
  logic                    eop_s;
  logic                    capture_s;
  logic                    handshake_s;
  logic [OW:0]             nb_s;
  logic [OW:0]             base_s;
  logic [OW:0]             end_s;
  logic [OW-1:0]           len_s;
  logic [FIELD_NUMBER-1:0] vld_s;

  assign accept_s    = bus.InBus_DataValid && read_q;
  assign sop_s       = accept_s && bus.InBus_DataSop;
  assign eop_s       = accept_s && bus.InBus_DataEop;
  assign capture_s   = accept_s && (sop_s || (state_q == S_BODY));
  assign handshake_s = (state_q == S_HOLD) && rdy_q && bus.OutBus_Ready;

  // Beat span in packet byte space; the running length saturates at the counter maximum.
  always_comb begin
    nb_s   = (bus.InBus_DataEop && (bus.InBus_Mod != MOD_W'(0))) ?
             (OW+1)'(bus.InBus_Mod) : (OW+1)'(BYTES);
    base_s = sop_s ? {(OW+1){1'b0}} : {1'b0, cnt_q};
    end_s  = base_s + nb_s;
    len_s  = end_s[OW] ? {OW{1'b1}} : end_s[OW-1:0];
  end

  // Shadow config writes; a Sop beat sees this cycle's write through the effective config.
  always_comb begin
    for (int i = 0; i < FIELD_NUMBER; i++) begin
      sh_off_d[i]  = (Cfg_We && (int'(Cfg_Sel) == i)) ? Cfg_Offset : sh_off_q[i];
      sh_sz_d[i]   = (Cfg_We && (int'(Cfg_Sel) == i)) ? Cfg_Size   : sh_sz_q[i];
      eff_off_s[i] = sop_s ? sh_off_d[i] : act_off_q[i];
      eff_sz_s[i]  = sop_s ? sh_sz_d[i]  : act_sz_q[i];
    end
  end

  // Byte capture: every field byte whose packet offset falls inside the current beat.
  always_comb begin
    logic [OW:0]      tgt_v;
    logic [OW:0]      idx_v;
    logic             hit_v;
    logic [MOD_W-1:0] bsel_v;
    cap_d  = sop_s ? '0 : cap_q;
    tgt_v  = {(OW+1){1'b0}};
    idx_v  = {(OW+1){1'b0}};
    hit_v  = 1'b0;
    bsel_v = {MOD_W{1'b0}};
    for (int i = 0; i < FIELD_NUMBER; i++) begin
      for (int j = 0; j < FIELD_SIZE_MAX; j++) begin
        tgt_v  = {1'b0, eff_off_s[i]} + (OW+1)'(j);
        idx_v  = tgt_v - base_s;
        bsel_v = idx_v[MOD_W-1:0];
        hit_v  = capture_s && (j < int'(eff_sz_s[i])) && (tgt_v >= base_s) &&
                 (tgt_v < end_s) && !tgt_v[OW];
        cap_d[i][j] = hit_v ? bus.InBus_Data[8*bsel_v +: 8] : cap_d[i][j];
      end
    end
  end

  // A field is good only with a legal size and an end inside the counted packet length.
  always_comb begin
    logic [OW:0] fend_v;
    fend_v = {(OW+1){1'b0}};
    for (int i = 0; i < FIELD_NUMBER; i++) begin
      fend_v   = {1'b0, eff_off_s[i]} + (OW+1)'(eff_sz_s[i]);
      vld_s[i] = (eff_sz_s[i] != SIZE_W'(0)) &&
                 (eff_sz_s[i] <= SIZE_W'(FIELD_SIZE_MAX)) &&
                 (fend_v <= {1'b0, len_s});
    end
  end

  // Packet FSM with capture state, config shadows and registered result outputs.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      read_q  <= 1'b1;
      rdy_q   <= 1'b0;
      vld_q   <= '0;
      err_q   <= '0;
      field_q <= '0;
      cap_q   <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < FIELD_NUMBER; i++) begin
        sh_off_q[i]  <= '0;
        sh_sz_q[i]   <= '0;
        act_off_q[i] <= '0;
        act_sz_q[i]  <= '0;
      end
    end else begin
      sh_off_q <= sh_off_d;
      sh_sz_q  <= sh_sz_d;

      case (state_q)
        S_IDLE: begin
          if (sop_s) begin
            state_q <= eop_s ? S_HOLD : S_BODY;
          end
        end
        S_BODY: begin
          if (eop_s) begin
            state_q <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (handshake_s) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase

      if (capture_s) begin
        cnt_q <= len_s;
        cap_q <= cap_d;
        if (sop_s) begin
          act_off_q <= sh_off_d;
          act_sz_q  <= sh_sz_d;
        end
      end

      if (capture_s && eop_s) begin
        field_q <= cap_d;
        vld_q   <= vld_s;
        err_q   <= ~vld_s;
        rdy_q   <= 1'b1;
        read_q  <= 1'b0;
      end else if (handshake_s) begin
        field_q <= '0;
        vld_q   <= '0;
        err_q   <= '0;
        rdy_q   <= 1'b0;
        read_q  <= 1'b1;
      end
    end
  end

  assign bus.InBus_DataRead         = read_q;
  assign bus.OutBus_AllValues_Ready = rdy_q;
  assign bus.OutBus_Valid           = vld_q;
  assign bus.OutBus_Field           = field_q;
  assign bus.error_offset_or_size   = err_q;

`ifdef PKT_EXTRACT_STATS_EN
  logic [31:0] pkt_cnt_q;
  logic [31:0] err_cnt_q;

  // Results counted at the moment they are handed downstream.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pkt_cnt_q <= 32'd0;
      err_cnt_q <= 32'd0;
    end else if (handshake_s) begin
      pkt_cnt_q <= pkt_cnt_q + 32'd1;
      if (|err_q) begin
        err_cnt_q <= err_cnt_q + 32'd1;
      end
    end
  end

  assign Stat_PktCnt = pkt_cnt_q;
  assign Stat_ErrCnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_packet_field_extractor.sv
// Directed bench for packet_field_extractor with hand-computed field values.
// Stats checks are compiled in when PKT_EXTRACT_STATS_EN is defined.
module tb_packet_field_extractor;
  localparam int DW  = 64;
  localparam int FN  = 4;
  localparam int FSM = 4;
  localparam int OW  = 8;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       cfg_we;
  logic [1:0] cfg_sel;
  logic [7:0] cfg_off;
  logic [2:0] cfg_sz;
`ifdef PKT_EXTRACT_STATS_EN
  logic [31:0] stat_pkt;
  logic [31:0] stat_err;
`endif

  int checks = 0;
  int errors = 0;

  packet_field_extractor_if #(.DATA_WIDTH(DW), .FIELD_NUMBER(FN), .FIELD_SIZE_MAX(FSM)) bus ();

  packet_field_extractor #(
    .DATA_WIDTH(DW), .FIELD_NUMBER(FN), .FIELD_SIZE_MAX(FSM), .OFFSET_WIDTH(OW)
  ) dut (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .bus(bus),
    .Cfg_We(cfg_we),
    .Cfg_Sel(cfg_sel),
    .Cfg_Offset(cfg_off),
    .Cfg_Size(cfg_sz)
`ifdef PKT_EXTRACT_STATS_EN
    ,
    .Stat_PktCnt(stat_pkt),
    .Stat_ErrCnt(stat_err)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic [7:0] s);
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[8*k +: 8] = s + 8'(k);
    return r;
  endfunction

  task automatic beat(input logic sop, input logic eop, input logic [2:0] mod, input logic [63:0] d);
    @(negedge Clk);
    bus.InBus_DataValid = 1'b1;
    bus.InBus_DataSop   = sop;
    bus.InBus_DataEop   = eop;
    bus.InBus_Mod       = mod;
    bus.InBus_Data      = d;
    @(posedge Clk);
    #1;
    bus.InBus_DataValid = 1'b0;
    bus.InBus_DataSop   = 1'b0;
    bus.InBus_DataEop   = 1'b0;
  endtask

  task automatic cfg(input logic [1:0] sel, input logic [7:0] off, input logic [2:0] sz);
    @(negedge Clk);
    cfg_we = 1'b1; cfg_sel = sel; cfg_off = off; cfg_sz = sz;
    @(posedge Clk);
    #1 cfg_we = 1'b0;
  endtask

  task automatic pkt3(input logic [7:0] s);
    beat(1'b1, 1'b0, 3'd0, mk(s));
    beat(1'b0, 1'b0, 3'd0, mk(s + 8'd8));
    beat(1'b0, 1'b1, 3'd0, mk(s + 8'd16));
  endtask

  // Called right after the Eop beat: result must be visible in the following cycle.
  task automatic chk_res(input string tag, input logic [3:0] v, input logic [3:0] e, input logic [127:0] f);
    @(negedge Clk);
    chk({tag, ".rdy"},   128'(bus.OutBus_AllValues_Ready), 128'd1);
    chk({tag, ".read"},  128'(bus.InBus_DataRead), 128'd0);
    chk({tag, ".valid"}, 128'(bus.OutBus_Valid), 128'(v));
    chk({tag, ".err"},   128'(bus.error_offset_or_size), 128'(e));
    chk({tag, ".field"}, bus.OutBus_Field, f);
  endtask

  task automatic handoff(input string tag);
    @(negedge Clk);
    bus.OutBus_Ready = 1'b1;
    @(posedge Clk);
    #1 bus.OutBus_Ready = 1'b0;
    @(negedge Clk);
    chk({tag, ".clr_rdy"},   128'(bus.OutBus_AllValues_Ready), 128'd0);
    chk({tag, ".clr_read"},  128'(bus.InBus_DataRead), 128'd1);
    chk({tag, ".clr_valid"}, 128'(bus.OutBus_Valid), 128'd0);
    chk({tag, ".clr_field"}, bus.OutBus_Field, 128'd0);
  endtask

  localparam logic [127:0] EXP1 = {32'h00060504, 32'h00000007, 32'h0C0B0A09, 32'h00000302};
  localparam logic [127:0] EXP2 = {32'h00060504, 32'h00000007, 32'h00000A09, 32'h00000302};
  localparam logic [127:0] EXP4 = {32'h00060504, 32'h00000007, 32'h0C0B0A09, 32'h00000605};
  localparam logic [127:0] EXP5 = {32'h00060504, 32'h00000007, 32'h0C0B0A09, 32'h00000504};
  localparam logic [127:0] EXP7 = {32'h00000000, 32'h00000000, 32'h00000000, 32'h00000302};

  initial begin
    Rst_n = 1'b0;
    cfg_we = 1'b0; cfg_sel = 2'd0; cfg_off = 8'd0; cfg_sz = 3'd0;
    bus.InBus_DataValid = 1'b0; bus.InBus_DataSop = 1'b0; bus.InBus_DataEop = 1'b0;
    bus.InBus_Mod = 3'd0; bus.InBus_Data = 64'd0; bus.OutBus_Ready = 1'b0;
    #12;
    chk("rst.read",  128'(bus.InBus_DataRead), 128'd1);
    chk("rst.rdy",   128'(bus.OutBus_AllValues_Ready), 128'd0);
    chk("rst.valid", 128'(bus.OutBus_Valid), 128'd0);
    chk("rst.err",   128'(bus.error_offset_or_size), 128'd0);
    chk("rst.field", bus.OutBus_Field, 128'd0);
    @(negedge Clk);
    Rst_n = 1'b1;

    cfg(2'd0, 8'd2, 3'd2);
    cfg(2'd1, 8'd9, 3'd4);
    cfg(2'd2, 8'd7, 3'd1);
    cfg(2'd3, 8'd4, 3'd3);

    // Non-Sop beats in IDLE are dropped.
    beat(1'b0, 1'b0, 3'd0, mk(8'h40));
    beat(1'b0, 1'b1, 3'd0, mk(8'h48));
    @(negedge Clk);
    chk("drop.rdy", 128'(bus.OutBus_AllValues_Ready), 128'd0);

    // Three-beat packet, then back-pressure for 5 cycles.
    pkt3(8'h00);
    chk_res("p1", 4'b1111, 4'b0000, EXP1);
    for (int c = 0; c < 5; c++) begin
      @(negedge Clk);
      chk("hold.read",  128'(bus.InBus_DataRead), 128'd0);
      chk("hold.field", bus.OutBus_Field, EXP1);
    end
    handoff("p1");

    // Truncated packet: Eop Mod=3 gives length 11.
    beat(1'b1, 1'b0, 3'd0, mk(8'h00));
    beat(1'b0, 1'b1, 3'd3, mk(8'h08));
    chk_res("p2", 4'b1101, 4'b0010, EXP2);
    handoff("p2");

    // Mid-packet config write applies only to the next packet.
    beat(1'b1, 1'b0, 3'd0, mk(8'h00));
    cfg(2'd0, 8'd5, 3'd2);
    beat(1'b0, 1'b0, 3'd0, mk(8'h08));
    beat(1'b0, 1'b1, 3'd0, mk(8'h10));
    chk_res("p3", 4'b1111, 4'b0000, EXP1);
    handoff("p3");
    pkt3(8'h00);
    chk_res("p4", 4'b1111, 4'b0000, EXP4);
    handoff("p4");

    // Config write on the Sop cycle applies to that packet.
    @(negedge Clk);
    cfg_we = 1'b1; cfg_sel = 2'd0; cfg_off = 8'd4; cfg_sz = 3'd2;
    bus.InBus_DataValid = 1'b1; bus.InBus_DataSop = 1'b1; bus.InBus_DataEop = 1'b0;
    bus.InBus_Mod = 3'd0; bus.InBus_Data = mk(8'h00);
    @(posedge Clk);
    #1;
    cfg_we = 1'b0; bus.InBus_DataValid = 1'b0; bus.InBus_DataSop = 1'b0;
    beat(1'b0, 1'b0, 3'd0, mk(8'h08));
    beat(1'b0, 1'b1, 3'd0, mk(8'h10));
    chk_res("p5", 4'b1111, 4'b0000, EXP5);
    handoff("p5");
    cfg(2'd0, 8'd2, 3'd2);

    // Sop inside BODY restarts capture; only one result.
    beat(1'b1, 1'b0, 3'd0, mk(8'h80));
    pkt3(8'h00);
    chk_res("p6", 4'b1111, 4'b0000, EXP1);
    handoff("p6");
    @(negedge Clk);
    chk("p6.single", 128'(bus.OutBus_AllValues_Ready), 128'd0);

    // Single-beat Sop&&Eop, Mod=4.
    beat(1'b1, 1'b1, 3'd4, mk(8'h00));
    chk_res("p7", 4'b0001, 4'b1110, EXP7);
    handoff("p7");
`ifdef PKT_EXTRACT_STATS_EN
    chk("stat.pkt", 128'(stat_pkt), 128'd7);
    chk("stat.err", 128'(stat_err), 128'd2);
`endif

    // Async reset while a result is held.
    pkt3(8'h00);
    chk_res("p8", 4'b1111, 4'b0000, EXP1);
    #2 Rst_n = 1'b0;
    #1;
    chk("rsth.rdy",   128'(bus.OutBus_AllValues_Ready), 128'd0);
    chk("rsth.read",  128'(bus.InBus_DataRead), 128'd1);
    chk("rsth.valid", 128'(bus.OutBus_Valid), 128'd0);
    chk("rsth.field", bus.OutBus_Field, 128'd0);
`ifdef PKT_EXTRACT_STATS_EN
    chk("rsth.stat", 128'(stat_pkt), 128'd0);
`endif
    @(negedge Clk);
    Rst_n = 1'b1;

    // Async reset during BODY; config is cleared afterwards.
    beat(1'b1, 1'b0, 3'd0, mk(8'h00));
    #2 Rst_n = 1'b0;
    #1;
    chk("rstb.read", 128'(bus.InBus_DataRead), 128'd1);
    chk("rstb.rdy",  128'(bus.OutBus_AllValues_Ready), 128'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    beat(1'b1, 1'b1, 3'd0, mk(8'h00));
    chk_res("p9", 4'b0000, 4'b1111, 128'd0);
    handoff("p9");
`ifdef PKT_EXTRACT_STATS_EN
    chk("stat2.pkt", 128'(stat_pkt), 128'd1);
    chk("stat2.err", 128'(stat_err), 128'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
